// File: rtl/mem_bus_arbiter_if.sv
// Requester, memory-bus and status signals of mem_bus_arbiter, bundled for port connection.
// Latency: none, wiring only. Backpressure: req is held until ack; the slave modport is the arbiter's view.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_lock;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_ack;
    logic [DATA_W-1:0] dma_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read_req;
    logic              mem_write_req;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [1:0]        grant;
    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
        output cpu_ack, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_ack, dma_rdata,
        output mem_addr, mem_read_req, mem_write_req, mem_wdata,
        input  mem_rdata,
        output grant, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
        input  cpu_ack, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_ack, dma_rdata,
        input  mem_addr, mem_read_req, mem_write_req, mem_wdata,
        output mem_rdata,
        input  grant, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the CPU and DMA ports, one transaction at a time (IDLE -> ISSUE -> CAPTURE).
// Latency: strobe 1 cycle after the request is sampled, ack + rdata 3 cycles after; one transaction per 3 cycles.
// Backpressure: a losing requester holds req until its ack. MEM_ARB_RR_EN: round-robin with cpu_lock, else fixed CPU priority.
module mem_bus_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input logic              clk,
    input logic              reset_n,
    mem_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              we_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;
    logic              cpu_ack_q;
    logic              dma_ack_q;
    logic [1:0]        grant_q;
    logic              busy_q;

    logic              cpu_vld;
    logic              dma_vld;
    logic              pick_cpu;
    logic              pick_dma;

    // The port being acked this cycle still shows req high; it must not be re-granted on stale addr/data.
    assign cpu_vld = bus.cpu_req & ~cpu_ack_q;
    assign dma_vld = bus.dma_req & ~dma_ack_q;

`ifdef MEM_ARB_RR_EN
    logic last_cpu;

    // A locked CPU that keeps req high owns the bus across its own ack cycle, so the DMA sits out that cycle too.
    assign pick_cpu = cpu_vld & (~dma_vld | ~last_cpu | bus.cpu_lock);
    assign pick_dma = dma_vld & ~pick_cpu & ~(bus.cpu_req & last_cpu & bus.cpu_lock);
`else
    logic unused_lock;

    assign unused_lock = bus.cpu_lock;
    assign pick_cpu    = cpu_vld;
    assign pick_dma    = dma_vld & ~bus.cpu_req;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            we_q        <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            grant_q     <= 2'b00;
            busy_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_cpu    <= 1'b0;
`endif
        end else begin
            cpu_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_cpu || pick_dma) begin
                        we_q        <= pick_cpu ? bus.cpu_we    : bus.dma_we;
                        mem_addr_q  <= pick_cpu ? bus.cpu_addr  : bus.dma_addr;
                        mem_wdata_q <= pick_cpu ? bus.cpu_wdata : bus.dma_wdata;
                        mem_read_q  <= pick_cpu ? ~bus.cpu_we   : ~bus.dma_we;
                        mem_write_q <= pick_cpu ? bus.cpu_we    : bus.dma_we;
                        grant_q     <= pick_cpu ? 2'b01 : 2'b10;
                        busy_q      <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        last_cpu    <= pick_cpu;
`endif
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    state       <= CAPTURE;
                end
                CAPTURE: begin
                    // mem_rdata is the memory's registered response to the ISSUE strobe.
                    if (grant_q[0]) begin
                        cpu_ack_q <= 1'b1;
                        if (!we_q) cpu_rdata_q <= bus.mem_rdata;
                    end else begin
                        dma_ack_q <= 1'b1;
                        if (!we_q) dma_rdata_q <= bus.mem_rdata;
                    end
                    grant_q <= 2'b00;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    grant_q     <= 2'b00;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.mem_read_req  = mem_read_q;
    assign bus.mem_write_req = mem_write_q;
    assign bus.cpu_ack       = cpu_ack_q;
    assign bus.cpu_rdata     = cpu_rdata_q;
    assign bus.dma_ack       = dma_ack_q;
    assign bus.dma_rdata     = dma_rdata_q;
    assign bus.grant         = grant_q;
    assign bus.busy          = busy_q;

`ifndef SYNTHESIS
    a_one_ack: assert property (@(posedge clk) disable iff (!reset_n) !(cpu_ack_q && dma_ack_q));
    a_one_strobe: assert property (@(posedge clk) disable iff (!reset_n) !(mem_read_q && mem_write_q));
    a_strobe_issue: assert property (@(posedge clk) disable iff (!reset_n)
        (mem_read_q || mem_write_q) |-> (state == ISSUE));
    a_grant_onehot: assert property (@(posedge clk) disable iff (!reset_n) grant_q != 2'b11);
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed requester scripts, expected bus/ack events queued up front.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        bit          we;
        bit          lock;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } stim_t;

    typedef struct {
        bit          port;
        bit          we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          scyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend_q[$];
    int   pend_cyc[$];

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mem_val(input logic [15:0] a);
        return (a == 16'h0005) ? 8'hA5 : ~a[7:0];
    endfunction

    // Registered memory: data appears the cycle after the read strobe, junk otherwise.
    always @(posedge clk) bus.mem_rdata <= bus.mem_read_req ? mem_val(bus.mem_addr) : 8'h5A;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic stim_t st(input bit we, input bit lock, input logic [15:0] addr, input logic [7:0] wdata);
        stim_t s;
        s.we = we; s.lock = lock; s.addr = addr; s.wdata = wdata;
        return s;
    endfunction

    task automatic expect_tx(input bit port, input bit we, input logic [15:0] addr,
                             input logic [7:0] wdata, input logic [7:0] rdata, input int scyc);
        exp_t e;
        e.port = port; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.scyc = scyc;
        exp_q.push_back(e);
    endtask

    task automatic set_port(input bit port, input bit req, input stim_t s);
        if (!port) begin
            bus.cpu_req = req; bus.cpu_we = s.we; bus.cpu_addr = s.addr;
            bus.cpu_wdata = s.wdata; bus.cpu_lock = s.lock;
        end else begin
            bus.dma_req = req; bus.dma_we = s.we; bus.dma_addr = s.addr; bus.dma_wdata = s.wdata;
        end
    endtask

    function automatic logic port_ack(input bit port);
        return port ? bus.dma_ack : bus.cpu_ack;
    endfunction

    // Holds each request until its ack, then presents the next one in the ack cycle (back-to-back).
    task automatic drive(input bit port, input stim_t list[$]);
        for (int i = 0; i < list.size(); i++) begin
            bit got;
            got = 1'b0;
            set_port(port, 1'b1, list[i]);
            for (int c = 0; c < 40 && !got; c++) begin
                @(posedge clk); #1;
                got = port_ack(port);
            end
            if (!got) begin
                checks++; errors++;
                $display("FAIL ack_timeout: port %0d item %0d got no ack within 40 cycles", port, i);
            end
        end
        set_port(port, 1'b0, st(1'b0, 1'b0, 16'h0000, 8'h00));
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   sc;
        if (bus.mem_read_req || bus.mem_write_req) begin
            chk("one_strobe", 32'(bus.mem_read_req & bus.mem_write_req), 0);
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_strobe: addr %0h, none expected (cycle %0d)", bus.mem_addr, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_cycle", cyc, e.scyc);
                chk("strobe_is_write", 32'(bus.mem_write_req), 32'(e.we));
                chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
                if (e.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
                chk("grant", 32'(bus.grant), 32'(e.port ? 2'b10 : 2'b01));
                chk("busy_issue", 32'(bus.busy), 1);
                pend_q.push_back(e);
                pend_cyc.push_back(cyc);
            end
        end
        if (bus.cpu_ack || bus.dma_ack) begin
            chk("one_ack", 32'(bus.cpu_ack & bus.dma_ack), 0);
            if (pend_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ack: cpu_ack %0b dma_ack %0b (cycle %0d)", bus.cpu_ack, bus.dma_ack, cyc);
            end else begin
                e  = pend_q.pop_front();
                sc = pend_cyc.pop_front();
                chk("ack_port", 32'(bus.dma_ack), 32'(e.port));
                chk("ack_latency", cyc - sc, 2);
                chk("rdata", 32'(e.port ? bus.dma_rdata : bus.cpu_rdata), 32'(e.rdata));
                chk("grant_idle", 32'(bus.grant), 0);
                chk("busy_idle", 32'(bus.busy), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t cl[$];
        stim_t dl[$];
        int    k;

        reset_n = 1'b0;
        set_port(1'b0, 1'b0, st(1'b0, 1'b0, 16'h0000, 8'h00));
        set_port(1'b1, 1'b0, st(1'b0, 1'b0, 16'h0000, 8'h00));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_acks", 32'({bus.cpu_ack, bus.dma_ack}), 0);
        chk("rst_strobes", 32'({bus.mem_read_req, bus.mem_write_req}), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
        chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
        chk("rst_dma_rdata", 32'(bus.dma_rdata), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_grant", 32'(bus.grant), 0);
        chk("idle_busy", 32'(bus.busy), 0);

        // Single CPU read.
        @(posedge clk); #1; k = cyc;
        expect_tx(1'b0, 1'b0, 16'h0005, 8'h00, 8'hA5, k + 1);
        cl = '{st(1'b0, 1'b0, 16'h0005, 8'h00)};
        drive(1'b0, cl);
        repeat (3) @(posedge clk);

        // DMA read then back-to-back write: write keeps dma_rdata, next grant one cycle after ack.
        @(posedge clk); #1; k = cyc;
        expect_tx(1'b1, 1'b0, 16'h0011, 8'h00, 8'hEE, k + 1);
        expect_tx(1'b1, 1'b1, 16'hE000, 8'h41, 8'hEE, k + 5);
        dl = '{st(1'b0, 1'b0, 16'h0011, 8'h00), st(1'b1, 1'b0, 16'hE000, 8'h41)};
        drive(1'b1, dl);
        repeat (3) @(posedge clk);

`ifdef MEM_ARB_RR_EN
        // Both saturated: alternate CPU/DMA, one transaction every 3 cycles.
        @(posedge clk); #1; k = cyc;
        expect_tx(1'b0, 1'b0, 16'h0010, 8'h00, 8'hEF, k + 1);
        expect_tx(1'b1, 1'b0, 16'h0020, 8'h00, 8'hDF, k + 4);
        expect_tx(1'b0, 1'b0, 16'h0012, 8'h00, 8'hED, k + 7);
        expect_tx(1'b1, 1'b0, 16'h0022, 8'h00, 8'hDD, k + 10);
        expect_tx(1'b0, 1'b0, 16'h0014, 8'h00, 8'hEB, k + 13);
        expect_tx(1'b1, 1'b0, 16'h0024, 8'h00, 8'hDB, k + 16);
        cl = '{st(1'b0, 1'b0, 16'h0010, 8'h00), st(1'b0, 1'b0, 16'h0012, 8'h00), st(1'b0, 1'b0, 16'h0014, 8'h00)};
        dl = '{st(1'b0, 1'b0, 16'h0020, 8'h00), st(1'b0, 1'b0, 16'h0022, 8'h00), st(1'b0, 1'b0, 16'h0024, 8'h00)};
        fork
            drive(1'b0, cl);
            drive(1'b1, dl);
        join
        repeat (3) @(posedge clk);

        // Locked CPU keeps three grants (with a bubble in each ack cycle); unlocking hands the next grant to DMA.
        @(posedge clk); #1; k = cyc;
        expect_tx(1'b0, 1'b0, 16'h0030, 8'h00, 8'hCF, k + 1);
        expect_tx(1'b0, 1'b0, 16'h0031, 8'h00, 8'hCE, k + 5);
        expect_tx(1'b0, 1'b0, 16'h0032, 8'h00, 8'hCD, k + 9);
        expect_tx(1'b1, 1'b0, 16'h0040, 8'h00, 8'hBF, k + 12);
        expect_tx(1'b0, 1'b0, 16'h0033, 8'h00, 8'hCC, k + 15);
        cl = '{st(1'b0, 1'b1, 16'h0030, 8'h00), st(1'b0, 1'b1, 16'h0031, 8'h00),
               st(1'b0, 1'b1, 16'h0032, 8'h00), st(1'b0, 1'b0, 16'h0033, 8'h00)};
        dl = '{st(1'b0, 1'b0, 16'h0040, 8'h00)};
        fork
            drive(1'b0, cl);
            drive(1'b1, dl);
        join
        repeat (3) @(posedge clk);
`else
        // Fixed priority: DMA waits until cpu_req drops, then wins in that same IDLE cycle.
        @(posedge clk); #1; k = cyc;
        expect_tx(1'b0, 1'b0, 16'h0060, 8'h00, 8'h9F, k + 1);
        expect_tx(1'b0, 1'b0, 16'h0061, 8'h00, 8'h9E, k + 5);
        expect_tx(1'b0, 1'b0, 16'h0062, 8'h00, 8'h9D, k + 9);
        expect_tx(1'b1, 1'b0, 16'h0070, 8'h00, 8'h8F, k + 12);
        cl = '{st(1'b0, 1'b0, 16'h0060, 8'h00), st(1'b0, 1'b0, 16'h0061, 8'h00), st(1'b0, 1'b0, 16'h0062, 8'h00)};
        dl = '{st(1'b0, 1'b0, 16'h0070, 8'h00)};
        fork
            drive(1'b0, cl);
            drive(1'b1, dl);
        join
        repeat (3) @(posedge clk);
`endif

        // Reset during ISSUE of a CPU read: strobe drops at once, no ack, then the next tie goes to the CPU.
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, st(1'b0, 1'b0, 16'h0050, 8'h00));
        @(posedge clk); #1;
        chk("issue_strobe_before_reset", 32'(bus.mem_read_req), 1);
        reset_n = 1'b0;
        #1;
        chk("reset_strobe_drop", 32'({bus.mem_read_req, bus.mem_write_req}), 0);
        chk("reset_busy_drop", 32'(bus.busy), 0);
        chk("reset_grant_drop", 32'(bus.grant), 0);
        chk("reset_cpu_rdata", 32'(bus.cpu_rdata), 0);
        chk("reset_dma_rdata", 32'(bus.dma_rdata), 0);
        set_port(1'b0, 1'b0, st(1'b0, 1'b0, 16'h0000, 8'h00));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_no_ack", 32'(bus.cpu_ack), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1; k = cyc;
        expect_tx(1'b0, 1'b0, 16'h0050, 8'h00, 8'hAF, k + 1);
        expect_tx(1'b1, 1'b0, 16'h0051, 8'h00, 8'hAE, k + 4);
        cl = '{st(1'b0, 1'b0, 16'h0050, 8'h00)};
        dl = '{st(1'b0, 1'b0, 16'h0051, 8'h00)};
        fork
            drive(1'b0, cl);
            drive(1'b1, dl);
        join

        repeat (5) @(posedge clk);
        chk("expected_strobes_left", exp_q.size(), 0);
        chk("expected_acks_left", pend_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
